// File: rtl/local_bus_pkg.sv
// Purpose: shared types and encodings for the 68030 local-bus cycle responder.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package local_bus_pkg;

    typedef enum logic [2:0] {
        ST_RELEASE,
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_BERR
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_ROM,
        CLS_RAM,
        CLS_SERIAL,
        CLS_VME
    } dev_class_t;

    // {DSACK1, DSACK0}, active low
    localparam logic [1:0] DSACK_32   = 2'b00;
    localparam logic [1:0] DSACK_16   = 2'b01;
    localparam logic [1:0] DSACK_8    = 2'b10;
    localparam logic [1:0] DSACK_NONE = 2'b11;

    // Port-size acknowledge presented for each device class.
    function automatic logic [1:0] dsack_for(input dev_class_t cls);
        logic [1:0] enc;
        case (cls)
            CLS_ROM:    enc = DSACK_16;
            CLS_RAM:    enc = DSACK_32;
            CLS_SERIAL: enc = DSACK_8;
            CLS_VME:    enc = DSACK_32;
            default:    enc = DSACK_NONE;
        endcase
        return enc;
    endfunction

endpackage

// File: rtl/cycle_counter.sv
// Purpose: loadable saturating down-counter (wait states) plus clearable saturating up-counter (timeout).
// Latency: counts change on the edge after load_i/step_i; flags are combinational from the registers.
// Backpressure: none; step_i is ignored for a counter already at its stop value.
//
// Ports:
//   clock, reset       - system clock, async active-high reset
//   load_i, load_val_i - load the down-counter and clear the up-counter
//   step_i             - decrement down-counter / increment up-counter, both saturating
//   limit_i            - value at which the up-counter stops
//   wait_zero_o        - down-counter has reached zero
//   tmo_term_o         - up-counter has reached limit_i
module cycle_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic             wait_zero_o,
    output logic             tmo_term_o
);

    logic [WIDTH-1:0] wait_q, wait_d;
    logic [WIDTH-1:0] tmo_q,  tmo_d;

    assign wait_zero_o = (wait_q == '0);
    assign tmo_term_o  = (tmo_q == limit_i);

    always_comb begin
        wait_d = wait_q;
        tmo_d  = tmo_q;
        if (load_i) begin
            wait_d = load_val_i;
            tmo_d  = '0;
        end else if (step_i) begin
            if (!wait_zero_o) wait_d = wait_q - WIDTH'(1);
            if (!tmo_term_o)  tmo_d  = tmo_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_q <= '0;
            tmo_q  <= '0;
        end else begin
            wait_q <= wait_d;
            tmo_q  <= tmo_d;
        end
    end

endmodule

// File: rtl/local_bus_responder.sv
// Purpose: 68030 local-bus cycle terminator; drives registered DSACK1/DSACK0 or BERR per decoded device.
// Latency: strobe visible after edge N+W+1 for a cycle sampled at edge N (W = device wait); VME on DTACK/BERR edge.
// Backpressure: holds the strobe until AS is sampled high; a cycle aborted by AS high is never terminated.
//
// Ports:
//   clock, reset                    - system clock, async active-high reset
//   cpu_as                          - CPU address strobe, active low
//   request_rom/ram/serial/vme      - active-low decoder requests (priority rom > ram > serial > vme)
//   vme_dtack, vme_berr             - active-low VME bridge terminations
//   cpu_dsack, cpu_berr             - active-low registered CPU terminations
module local_bus_responder
    import local_bus_pkg::*;
#(
    parameter int ROM_WAIT       = 3,
    parameter int RAM_WAIT       = 1,
    parameter int SERIAL_WAIT    = 4,
    parameter int TIMEOUT_CYCLES = 200,
    parameter int COUNT_WIDTH    = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cpu_as,
    input  logic       request_rom,
    input  logic       request_ram,
    input  logic       request_serial,
    input  logic       request_vme,
    input  logic       vme_dtack,
    input  logic       vme_berr,
    output logic [1:0] cpu_dsack,
    output logic       cpu_berr
);

    localparam logic [COUNT_WIDTH-1:0] ROM_LOAD    = COUNT_WIDTH'(ROM_WAIT);
    localparam logic [COUNT_WIDTH-1:0] RAM_LOAD    = COUNT_WIDTH'(RAM_WAIT);
    localparam logic [COUNT_WIDTH-1:0] SERIAL_LOAD = COUNT_WIDTH'(SERIAL_WAIT);
    localparam logic [COUNT_WIDTH-1:0] TMO_LIMIT   = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    dev_class_t       class_q, class_d;
    dev_class_t       req_class;
    logic [1:0]       dsack_q, dsack_d;
    logic             berr_q,  berr_d;
    logic             cnt_load, cnt_step;
    logic [COUNT_WIDTH-1:0] cnt_load_val;
    logic             wait_zero, tmo_term;
    logic             is_local;

    cycle_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_cycle_counter (
        .clock       (clock),
        .reset       (reset),
        .load_i      (cnt_load),
        .load_val_i  (cnt_load_val),
        .step_i      (cnt_step),
        .limit_i     (TMO_LIMIT),
        .wait_zero_o (wait_zero),
        .tmo_term_o  (tmo_term)
    );

    always_comb begin
        req_class = CLS_NONE;
        if      (!request_rom)    req_class = CLS_ROM;
        else if (!request_ram)    req_class = CLS_RAM;
        else if (!request_serial) req_class = CLS_SERIAL;
        else if (!request_vme)    req_class = CLS_VME;
    end

    assign is_local = (class_q == CLS_ROM) || (class_q == CLS_RAM) || (class_q == CLS_SERIAL);

    always_comb begin
        state_d      = state_q;
        class_d      = class_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_step     = 1'b0;
        case (state_q)
            // After reset, wait for AS to go high so a cycle cut short by reset is never terminated.
            ST_RELEASE: if (cpu_as) state_d = ST_IDLE;
            ST_IDLE: begin
                if (!cpu_as) begin
                    state_d  = ST_WAIT;
                    class_d  = req_class;
                    cnt_load = 1'b1;
                    case (req_class)
                        CLS_ROM:    cnt_load_val = ROM_LOAD;
                        CLS_RAM:    cnt_load_val = RAM_LOAD;
                        CLS_SERIAL: cnt_load_val = SERIAL_LOAD;
                        default:    cnt_load_val = '0;
                    endcase
                end
            end
            ST_WAIT: begin
                // Order matters: abort, then real termination, then timeout.
                if (cpu_as)                                state_d = ST_IDLE;
                else if ((class_q == CLS_VME) && !vme_berr)  state_d = ST_BERR;
                else if ((class_q == CLS_VME) && !vme_dtack) state_d = ST_ACK;
                else if (is_local && wait_zero)            state_d = ST_ACK;
                else if (tmo_term)                         state_d = ST_BERR;
                else                                       cnt_step = 1'b1;
            end
            ST_ACK, ST_BERR: if (cpu_as) state_d = ST_IDLE;
            default: state_d = ST_RELEASE;
        endcase
    end

    // Strobes are decoded from the next state so they appear on the edge that enters ACK/BERR.
    assign dsack_d = (state_d == ST_ACK) ? dsack_for(class_d) : DSACK_NONE;
    assign berr_d  = (state_d != ST_BERR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_RELEASE;
            class_q <= CLS_NONE;
            dsack_q <= DSACK_NONE;
            berr_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            dsack_q <= dsack_d;
            berr_q  <= berr_d;
        end
    end

    assign cpu_dsack = dsack_q;
    assign cpu_berr  = berr_q;

endmodule

// File: tb/tb_local_bus_responder.sv
// Purpose: randomized self-checking bench for local_bus_responder with a transaction-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_local_bus_responder;

    localparam int TO = 200;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_as = 1'b1;
    logic       request_rom = 1'b1, request_ram = 1'b1, request_serial = 1'b1, request_vme = 1'b1;
    logic       vme_dtack = 1'b1, vme_berr = 1'b1;
    logic [1:0] cpu_dsack;
    logic       cpu_berr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int code;   // {berr, dsack1, dsack0}
        int at;     // edge after which the strobe first appears
        int rel;    // edge after which the strobe is released
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   active = 1'b0;

    local_bus_responder dut (
        .clock          (clock),
        .reset          (reset),
        .cpu_as         (cpu_as),
        .request_rom    (request_rom),
        .request_ram    (request_ram),
        .request_serial (request_serial),
        .request_vme    (request_vme),
        .vme_dtack      (vme_dtack),
        .vme_berr       (vme_berr),
        .cpu_dsack      (cpu_dsack),
        .cpu_berr       (cpu_berr)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference model: which edge (relative to the sampling edge) terminates the cycle, and how.
    function automatic void model(input logic [3:0] req_n, input int vme_d, input int vme_kind,
                                  output int t, output int code);
        int w;
        int ack;
        w = 0; ack = 0;
        if (!req_n[3])      begin w = 3; ack = 3'b101; end
        else if (!req_n[2]) begin w = 1; ack = 3'b100; end
        else if (!req_n[1]) begin w = 4; ack = 3'b110; end
        if (ack != 0) begin
            if (w + 1 <= TO) begin t = w + 1; code = ack; end
            else             begin t = TO;    code = 3'b011; end
        end else if (!req_n[0]) begin
            if (vme_d > 0 && vme_d <= TO) begin
                t = vme_d;
                code = (vme_kind == 0) ? 3'b100 : 3'b011;
            end else begin
                t = TO; code = 3'b011;
            end
        end else begin
            t = TO; code = 3'b011;
        end
    endfunction

    // req_n = {rom, ram, serial, vme}; vme_kind 0=dtack 1=berr 2=both; abort_at 0 = no abort.
    task automatic run_txn(input logic [3:0] req_n, input int vme_d, input int vme_kind,
                           input int abort_at, input int hold, input int gap);
        int t, code, n, last, ab;
        bit is_vme;
        exp_t e;
        model(req_n, vme_d, vme_kind, t, code);
        is_vme = (req_n[3:1] == 3'b111) && !req_n[0];
        ab = (abort_at > t) ? t : abort_at;
        cpu_as = 1'b0;
        {request_rom, request_ram, request_serial, request_vme} = req_n;
        vme_dtack = 1'b1; vme_berr = 1'b1;
        step();
        n = cyc;
        if (ab == 0) begin
            e.code = code; e.at = n + t; e.rel = n + t + hold + 1;
            q.push_back(e);
        end
        // Requests are latched at the sampling edge; later changes must not matter.
        {request_rom, request_ram, request_serial, request_vme} = 4'($urandom_range(0, 15));
        last = (ab != 0) ? ab : t + hold;
        for (int k = 1; k <= last; k++) begin
            if (ab != 0 && k == ab) cpu_as = 1'b1;
            if (is_vme && vme_d > 0 && k >= vme_d) begin
                vme_dtack = (vme_kind == 1) ? 1'b1 : 1'b0;
                vme_berr  = (vme_kind == 0) ? 1'b1 : 1'b0;
            end else if (is_vme) begin
                vme_dtack = 1'b1; vme_berr = 1'b1;
            end else begin
                vme_dtack = 1'($urandom_range(0, 1));
                vme_berr  = 1'($urandom_range(0, 1));
            end
            step();
        end
        if (ab == 0) begin
            cpu_as = 1'b1;
            step();
        end
        {request_rom, request_ram, request_serial, request_vme} = 4'hF;
        vme_dtack = 1'b1; vme_berr = 1'b1;
        repeat (gap) step();
    endtask

    // Monitor: pops an expectation whenever the DUT starts a termination strobe.
    always @(negedge clock) begin
        int code;
        if (mon_en) begin
            code = {cpu_berr, cpu_dsack};
            check("dsack_with_berr", (!cpu_berr && cpu_dsack != 2'b11) ? 1 : 0, 0);
            if (!active && code != 3'b111) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_strobe: got code %0d expected none (edge %0d)", code, cyc);
                    cur.code = code; cur.at = cyc; cur.rel = -1;
                end else begin
                    cur = q.pop_front();
                    check("strobe_code", code, cur.code);
                    check("strobe_edge", cyc, cur.at);
                end
                active = 1'b1;
            end else if (active && code == 3'b111) begin
                if (cur.rel >= 0) check("release_edge", cyc, cur.rel);
                active = 1'b0;
            end else if (active && code != cur.code) begin
                check("strobe_hold", code, cur.code);
                cur.code = code;
            end
        end
    end

    initial begin
        logic [3:0] rq;
        int vd, vk, ab;
        #12;
        check("reset_dsack", int'(cpu_dsack), 3);
        check("reset_berr", int'(cpu_berr), 1);
        reset = 1'b0;
        mon_en = 1'b1;
        step();                                   // RELEASE -> IDLE with AS high
        check("idle_dsack", int'(cpu_dsack), 3);
        check("idle_berr", int'(cpu_berr), 1);

        // Directed: RAM, serial, ROM, VME dtack, VME both, VME silent, timeout boundaries, abort.
        run_txn(4'b1011, 0, 0, 0, 1, 0);
        run_txn(4'b1101, 0, 0, 0, 0, 1);
        run_txn(4'b0111, 0, 0, 0, 2, 0);
        run_txn(4'b1110, 10, 0, 0, 1, 0);
        run_txn(4'b1110, 5, 2, 0, 1, 0);
        run_txn(4'b1110, 0, 0, 0, 3, 0);
        run_txn(4'b1110, 200, 0, 0, 0, 0);
        run_txn(4'b1110, 201, 0, 0, 0, 0);
        run_txn(4'b0111, 0, 0, 2, 0, 0);          // abort before ROM acknowledge
        run_txn(4'b1011, 0, 0, 2, 0, 0);          // abort on the would-be acknowledge edge
        run_txn(4'b0000, 0, 0, 0, 0, 0);          // all requests: ROM wins
        run_txn(4'b1111, 0, 0, 0, 1, 0);          // no request: timeout only
        run_txn(4'b1011, 0, 0, 0, 0, 0);          // back-to-back with a single AS-high edge
        run_txn(4'b1011, 0, 0, 0, 0, 0);

        // Reset pulsed mid-cycle with AS still low: no termination until AS returns high.
        cpu_as = 1'b0;
        {request_rom, request_ram, request_serial, request_vme} = 4'b0111;
        step();
        step();
        #1 reset = 1'b1;
        #1;
        check("midreset_dsack", int'(cpu_dsack), 3);
        check("midreset_berr", int'(cpu_berr), 1);
        reset = 1'b0;
        repeat (6) step();
        check("release_dsack", int'(cpu_dsack), 3);
        check("release_berr", int'(cpu_berr), 1);
        cpu_as = 1'b1;
        {request_rom, request_ram, request_serial, request_vme} = 4'hF;
        step();
        run_txn(4'b1011, 0, 0, 0, 0, 0);

        // Random transactions.
        for (int i = 0; i < 50; i++) begin
            rq = 4'($urandom_range(0, 15));
            vd = int'($urandom_range(0, 19));
            if (vd == 0)      vd = 0;
            else if (vd == 1) vd = 200;
            else if (vd == 2) vd = 201;
            else              vd = int'($urandom_range(1, 12));
            vk = int'($urandom_range(0, 2));
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : 0;
            run_txn(rq, vd, vk, ab, int'($urandom_range(0, 2)), int'($urandom_range(0, 1)));
        end

        repeat (3) step();
        check("queue_drained", q.size(), 0);
        check("no_strobe_left", int'(active), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
